// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch widths, boot address and FIFO entry type
package fetch_unit_pkg;

    localparam int ADDR_W     = 16;
    localparam int INST_W     = 32;
    localparam int FIFO_DEPTH = 4;

    localparam logic [ADDR_W-1:0] BOOT_PC = '0;

    // One buffered fetch: the word and the address it came from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] data;
    } fetch_entry_t;

    // Sequential next word address, wrapping at the top of the address space
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and decode handshake bundle
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// rtl/fetch_unit_sync_fifo.sv - prefetch FIFO with clear and registered head
module sync_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output fetch_entry_t                 head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointer/count update; clear wins over any same-cycle push or pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, credit-based instruction fetch and redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = BOOT_PC
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic              run_q, run_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;

    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              issue;
    logic [ADDR_W-1:0] fetch_addr;
    logic              push;
    logic              pop;

    // Issue/credit: buffered plus in-flight words never exceed FIFO depth,
    // except a redirect which always fetches because it also empties the FIFO.
    // run_q holds off the first request until one clock after reset release.
    always_comb begin
        occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        credit_ok  = occupancy < (CNT_W+1)'(DEPTH);
        issue      = run_q && (credit_ok || bus.redirect_valid);
        fetch_addr = bus.redirect_valid ? bus.redirect_pc : pc_q;
        pc_d       = issue ? pc_inc(fetch_addr) : pc_q;
        inflight_d = issue;
        resp_pc_d  = issue ? fetch_addr : resp_pc_q;
        run_d      = 1'b1;
        push       = inflight_q && !bus.redirect_valid;
        pop        = !fifo_empty && bus.inst_ready && !bus.redirect_valid;
        push_entry = '{pc: resp_pc_q, data: bus.imem_rdata};
    end

    // PC and in-flight tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            resp_pc_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            resp_pc_q  <= resp_pc_d;
            run_q      <= run_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (bus.redirect_valid),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_addr;
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst_data  = fifo_head.data;
    assign bus.inst_pc    = fifo_head.pc;

endmodule
